// File: rtl/step_sequencer.sv
// Pattern step sequencer driving a voice's tone_freq and gate from a STEPS-entry
// pattern. Each step is reloaded through a one-cycle LOAD so the voice gate always retriggers.
module step_sequencer #(
  parameter int STEPS     = 8,
  parameter int TICK_DIV  = 1000,
  parameter int FREQ_BITS = 16,
  localparam int AW       = $clog2(STEPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [15:0]          step_ticks,
  input  logic [15:0]          gate_ticks,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [FREQ_BITS-1:0] wr_freq,
  input  logic                 wr_rest,
  output logic [FREQ_BITS-1:0] tone_freq,
  output logic                 gate,
  output logic [AW-1:0]        step_idx,
  output logic                 step_strobe
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    GATE_ON  = 2'd2,
    GATE_OFF = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [PW-1:0]        pre_r;
  logic [15:0]          tick_cnt_r;
  logic [15:0]          step_ticks_r;
  logic [15:0]          gate_ticks_r;
  logic                 rest_r;
  logic [FREQ_BITS-1:0] pat_freq_r [STEPS];
  logic                 pat_rest_r [STEPS];

  logic                 running_s;
  logic                 tick_s;
  logic [15:0]          cnt_inc_s;
  logic                 step_end_s;
  logic                 gate_end_s;
  logic                 load_s;
  logic [AW-1:0]        load_addr_s;
  logic                 gate_nxt_s;
  logic                 strobe_nxt_s;

  // Tick detection and end-of-step / end-of-gate conditions
  always_comb begin
    running_s  = (state_r == GATE_ON) || (state_r == GATE_OFF);
    cnt_inc_s  = tick_cnt_r + 16'd1;
    step_end_s = (cnt_inc_s >= step_ticks_r);
    gate_end_s = (cnt_inc_s >= gate_ticks_r);
    if (running_s && (pre_r == PRE_MAX)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; step end takes priority over gate end on a shared tick
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (run) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (!run) begin
          state_nxt_s = IDLE;
        end else if (!rest_r && (gate_ticks_r != 16'd0)) begin
          state_nxt_s = GATE_ON;
        end else begin
          state_nxt_s = GATE_OFF;
        end
      end
      GATE_ON: begin
        if (!run) begin
          state_nxt_s = IDLE;
        end else if (tick_s && step_end_s) begin
          state_nxt_s = LOAD;
        end else if (tick_s && gate_end_s) begin
          state_nxt_s = GATE_OFF;
        end else begin
          state_nxt_s = GATE_ON;
        end
      end
      GATE_OFF: begin
        if (!run) begin
          state_nxt_s = IDLE;
        end else if (tick_s && step_end_s) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = GATE_OFF;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track the state
  always_comb begin
    load_s       = (state_nxt_s == LOAD);
    strobe_nxt_s = load_s;
    gate_nxt_s   = (state_nxt_s == GATE_ON);
    if (state_r == IDLE) begin
      load_addr_s = '0;
    end else begin
      load_addr_s = step_idx + AW'(1);
    end
  end

  // Step datapath: the pattern is read on the edge entering LOAD, so a same-edge write is not seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_freq    <= '0;
      gate         <= 1'b0;
      step_idx     <= '0;
      step_strobe  <= 1'b0;
      pre_r        <= '0;
      tick_cnt_r   <= 16'd0;
      step_ticks_r <= 16'd1;
      gate_ticks_r <= 16'd0;
      rest_r       <= 1'b1;
    end else begin
      step_strobe <= strobe_nxt_s;
      gate        <= gate_nxt_s;
      if (load_s) begin
        tone_freq    <= pat_freq_r[load_addr_s];
        rest_r       <= pat_rest_r[load_addr_s];
        step_idx     <= load_addr_s;
        step_ticks_r <= (step_ticks == 16'd0) ? 16'd1 : step_ticks;
        gate_ticks_r <= gate_ticks;
        tick_cnt_r   <= 16'd0;
        pre_r        <= '0;
      end else if (running_s && (state_nxt_s != IDLE)) begin
        if (tick_s) begin
          pre_r      <= '0;
          tick_cnt_r <= cnt_inc_s;
        end else begin
          pre_r      <= pre_r + PW'(1);
          tick_cnt_r <= tick_cnt_r;
        end
      end else begin
        pre_r      <= '0;
        tick_cnt_r <= 16'd0;
      end
    end
  end

  // Pattern memory; reset leaves every step a silent rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        pat_freq_r[i] <= '0;
        pat_rest_r[i] <= 1'b1;
      end
    end else if (wr_en) begin
      pat_freq_r[wr_addr] <= wr_freq;
      pat_rest_r[wr_addr] <= wr_rest;
    end
  end

endmodule
